frontend_cmd_arbiter: RTL and testbench
=======================================

# frontend_cmd_arbiter

Shares the single 32-bit command channel into the frontend reset/command decoder among NREQ independent command sources (backend link, housekeeping sequencer, debug port, ...). Grants are round-robin, except that any source presenting the reset code wins immediately. After a reset word is delivered, the block enforces a hold-off window so no command reaches the frontend while its system reset is still asserted. Holds at most one word in flight; output is a registered valid/ready channel.

## Interface

Parameters:
- NREQ, 4: number of requesters (2..8).
- RST_CODE, 32'hF000_0000: command word that triggers frontend reset.
- HOLDOFF, 32: cycles of traffic blackout after a reset word is delivered (>=1); matches frontend reset pulse length.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_data  in  NREQ*32  requester i word at bits [32*i+31:32*i].
- req_valid  in  NREQ  requester i has a word; must not depend on req_ready.
- req_ready  out  NREQ  one-hot (or zero) accept; combinational from state, req_valid, last_grant.
- data_out  out  32  command word to frontend.
- valid_out  out  1  data_out valid.
- ready_out  in  1  frontend accepts data_out.
- busy  out  1  high while in HOLDOFF.
- last_grant  out  clog2(NREQ)  index of most recently accepted requester.

## Operation

- States: IDLE, SEND, HOLDOFF.
- IDLE: if any req_valid, select grant index g:
  - any valid requester with word == RST_CODE: lowest such index;
  - otherwise first valid index scanning last_grant+1, last_grant+2, ... modulo NREQ.
  - req_ready[g]=1 (all others 0); on the edge: data_out<=word, valid_out<=1, last_grant<=g, rst_flag<=(word==RST_CODE), go SEND.
  - no valid requester: req_ready=0, stay IDLE.
- SEND: req_ready=0; valid_out, data_out held stable. On edge with ready_out=1: valid_out<=0; if rst_flag go HOLDOFF, load counter HOLDOFF-1; else go IDLE.
- HOLDOFF: req_ready=0, busy=1. Counter decrements each cycle; on edge with counter==0 go IDLE. Exactly HOLDOFF cycles spent in HOLDOFF.
- last_grant updates on every accept, including reset-code grants.
- Reset values: state IDLE, data_out 0, valid_out 0, busy 0, last_grant NREQ-1 (first round-robin grant goes to 0), counter 0, rst_flag 0; req_ready 0 while rst high.
- rst mid-operation: in-flight word discarded (never re-presented), hold-off aborted; outputs take reset values asynchronously.
- Requesters' words are never reordered or duplicated; each accepted word appears on data_out exactly once.

## Timing

- Accept at edge T (req_valid[g]&req_ready[g]) -> valid_out=1 with that word from T+1.
- Output handshake at edge E -> valid_out=0 after E; next accept earliest at edge E+1 (non-reset word). Peak throughput: 1 word per 2 cycles with ready_out tied high.
- Reset word handshake at edge E -> busy=1 for cycles after E through E+HOLDOFF; next accept earliest at edge E+HOLDOFF+1.
- ready_out low: unlimited stall, no accepts, outputs stable.
- Simultaneous reset codes: lowest index wins; the other reset code is served after hold-off (then again hold-off).
- A reset code beats round-robin order even if its requester was just granted.

## Test plan

- Requester 0 sends 32'h0000_1234, ready_out=1 -> req_ready[0] high one cycle at T, data_out=32'h0000_1234 with valid_out=1 exactly cycle T+1, last_grant=0, busy=0.
- All 4 requesters continuously valid with words 32'hA0..A3, ready_out=1 -> output order A0,A1,A2,A3,A0,A1; one word every 2 cycles.
- last_grant=0, requesters 1 and 3 valid with normal words, requester 2 presents 32'hF000_0000 -> 2 granted first; after its handshake busy high for exactly 32 cycles, req_ready all 0; then requester 3 granted, then 1.
- Requesters 1 and 3 both present 32'hF000_0000 -> 1 delivered, 32-cycle hold-off, 3 delivered, second 32-cycle hold-off.
- ready_out held low 10 cycles while word 32'h0000_00FF pending -> data_out/valid_out unchanged all 10 cycles, no req_ready; handshake on cycle 11, state returns to IDLE.
- rst pulsed during SEND and again during HOLDOFF -> valid_out and busy drop immediately without clock; after release, requesters 0..3 valid -> first grant goes to requester 0.

Source files
------------

// File: rtl/frontend_cmd_arbiter.sv
// frontend_cmd_arbiter: shares the single 32-bit command channel into the
// frontend reset/command decoder among NREQ requesters. Grants are
// round-robin, but a reset-code word always wins (lowest index first). After
// a reset word is handed to the frontend, a HOLDOFF-cycle blackout keeps
// further commands away while the frontend reset is asserted.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_data/valid    per-requester 32-bit word and valid (word i at [32*i+:32])
//   req_ready         one-hot accept, combinational from state/req_valid/last_grant
//   data_out/valid_out/ready_out  registered valid/ready output channel
//   busy              high while in the post-reset hold-off window
//   last_grant        index of the most recently accepted requester
module frontend_cmd_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter logic [31:0] RST_CODE = 32'hF000_0000,
  parameter int unsigned HOLDOFF  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ*32-1:0]      req_data,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  output logic [31:0]             data_out,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] last_grant
);

  localparam int unsigned GW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD} state_t;

  state_t          state, state_d;
  logic [31:0]     data_d;
  logic            valid_d;
  logic            busy_d;
  logic [GW-1:0]   grant_d;
  logic            rst_flag, rst_flag_d;
  logic [CW-1:0]   cnt, cnt_d;

  logic            any_valid;
  logic            found_rst;
  logic [GW-1:0]   rst_idx;
  logic [GW-1:0]   rr_idx;
  logic [GW-1:0]   gnt;
  logic [31:0]     gnt_word;

  // Grant selection: lowest reset-code requester, else round-robin after last_grant.
  always_comb begin
    any_valid = |req_valid;
    found_rst = 1'b0;
    rst_idx   = '0;
    rr_idx    = '0;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      if (req_valid[i-1] && (req_data[32*(i-1) +: 32] == RST_CODE)) begin
        found_rst = 1'b1;
        rst_idx   = GW'(i-1);
      end
    end
    // Descending scan so the smallest offset from last_grant is kept.
    for (int unsigned k = NREQ; k >= 1; k--) begin
      if (req_valid[GW'((32'(last_grant) + k) % NREQ)]) begin
        rr_idx = GW'((32'(last_grant) + k) % NREQ);
      end
    end
    gnt      = found_rst ? rst_idx : rr_idx;
    gnt_word = req_data[32*32'(gnt) +: 32];
  end

  // Next-state and combinational accept.
  always_comb begin
    state_d    = state;
    data_d     = data_out;
    valid_d    = valid_out;
    grant_d    = last_grant;
    rst_flag_d = rst_flag;
    cnt_d      = cnt;
    req_ready  = '0;
    case (state)
      S_IDLE: begin
        if (any_valid && !rst) begin
          req_ready[gnt] = 1'b1;
          data_d         = gnt_word;
          valid_d        = 1'b1;
          grant_d        = gnt;
          rst_flag_d     = (gnt_word == RST_CODE);
          state_d        = S_SEND;
        end
      end
      S_SEND: begin
        if (ready_out) begin
          valid_d = 1'b0;
          if (rst_flag) begin
            state_d = S_HOLD;
            cnt_d   = CW'(HOLDOFF - 1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      data_out   <= '0;
      valid_out  <= 1'b0;
      busy       <= 1'b0;
      last_grant <= GW'(NREQ - 1);
      rst_flag   <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_d;
      data_out   <= data_d;
      valid_out  <= valid_d;
      busy       <= busy_d;
      last_grant <= grant_d;
      rst_flag   <= rst_flag_d;
      cnt        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_frontend_cmd_arbiter.sv
// Directed testbench for frontend_cmd_arbiter (NREQ=4, HOLDOFF=32).
module tb_frontend_cmd_arbiter;

  localparam int unsigned NREQ = 4;
  localparam logic [31:0] RSTC = 32'hF000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [31:0]      data_out;
  logic             valid_out;
  logic             ready_out;
  logic             busy;
  logic [1:0]       last_grant;

  int n_cmp = 0;
  int n_bad = 0;

  frontend_cmd_arbiter #(.NREQ(NREQ), .RST_CODE(RSTC), .HOLDOFF(32)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .data_out(data_out), .valid_out(valid_out),
    .ready_out(ready_out), .busy(busy), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    ready_out = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      if (req_ready != '0) n = n + 1000;
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    int bad;
    int k;
    req_data = '0;

    // Reset values
    do_reset();
    check("rst_valid", 32'(valid_out), 0);
    check("rst_data", data_out, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_lastg", 32'(last_grant), 3);

    // Single word from requester 0
    req_data[31:0] = 32'h0000_1234;
    req_valid      = 4'b0001;
    #1 check("t1_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    check("t1_valid", 32'(valid_out), 1);
    check("t1_data", data_out, 32'h0000_1234);
    check("t1_lastg", 32'(last_grant), 0);
    check("t1_busy", 32'(busy), 0);
    check("t1_noready", 32'(req_ready), 0);
    step();
    check("t1_valid_drop", 32'(valid_out), 0);

    // Round-robin with all four requesters continuously valid
    do_reset();
    for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'hA0 + 32'(i);
    req_valid = 4'b1111;
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("rr_valid%0d", c), 32'(valid_out), 32'(c % 2));
      if (c % 2 == 1) check($sformatf("rr_data%0d", c), data_out, 32'hA0 + 32'(((c - 1) / 2) % 4));
    end
    req_valid = '0;
    step();

    // Reset code beats round-robin; hold-off; then RR resumes at 3, 1
    do_reset();
    req_data[31:0] = 32'h55;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    check("t3_lastg0", 32'(last_grant), 0);
    req_data[63:32]  = 32'h0000_0011;
    req_data[95:64]  = RSTC;
    req_data[127:96] = 32'h0000_0033;
    req_valid = 4'b1110;
    #1 check("t3_ready2", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b1010;
    check("t3_data", data_out, RSTC);
    check("t3_lastg2", 32'(last_grant), 2);
    step();
    check("t3_busy", 32'(busy), 1);
    count_busy(n);
    check("t3_holdlen", 32'(n), 32);
    check("t3_ready3", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b0010;
    check("t3_data3", data_out, 32'h0000_0033);
    step();
    check("t3_ready1", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    check("t3_data1", data_out, 32'h0000_0011);
    step();

    // Two simultaneous reset codes
    do_reset();
    req_data[63:32]  = RSTC;
    req_data[127:96] = RSTC;
    req_valid = 4'b1010;
    #1 check("t4_ready1", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b1000;
    check("t4_lastg1", 32'(last_grant), 1);
    check("t4_data1", data_out, RSTC);
    step();
    count_busy(n);
    check("t4_hold1", 32'(n), 32);
    check("t4_ready3", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    check("t4_lastg3", 32'(last_grant), 3);
    check("t4_data3", data_out, RSTC);
    step();
    count_busy(n);
    check("t4_hold2", 32'(n), 32);

    // Output stall with ready_out low
    do_reset();
    ready_out = 1'b0;
    req_data[31:0]  = 32'h0000_00FF;
    req_data[63:32] = 32'h0000_0077;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0010;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (data_out !== 32'hFF || valid_out !== 1'b1 || req_ready !== '0) bad++;
      step();
    end
    check("t5_stall", 32'(bad), 0);
    ready_out = 1'b1;
    check("t5_data", data_out, 32'h0000_00FF);
    step();
    check("t5_valid_drop", 32'(valid_out), 0);
    check("t5_idle_ready", 32'(req_ready), 32'b0010);
    req_valid = '0;
    step();

    // Asynchronous reset during SEND and during HOLDOFF
    do_reset();
    req_data[31:0] = 32'h0000_0042;
    req_valid = 4'b0001;
    step();
    check("t6_send_valid", 32'(valid_out), 1);
    rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(valid_out), 0);
    check("t6_async_ready", 32'(req_ready), 0);
    #1 rst = 1'b0;
    req_valid = '0;
    step();
    req_data[31:0] = RSTC;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    k = 0;
    step();
    step();
    check("t6_hold_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_lastg", 32'(last_grant), 3);
    #1 rst = 1'b0;
    req_data = {32'h3, 32'h2, 32'h1, 32'h0};
    req_valid = 4'b1111;
    #1 check("t6_first_grant", 32'(req_ready), 32'b0001 + 32'(k));
    step();
    check("t6_first_data", data_out, 32'h0);
    req_valid = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
